usb_tx_packet_sequencer: RTL

Parametrised USB transmit packet sequencer. It builds a complete packet as a byte stream (SYNC, PID, payload, CRC16) and hands it byte-by-byte to the downstream bit serializer / bit stuffer / NRZI encoder over a valid/ready handshake. It computes the data CRC16 internally and pulls payload bytes from the TX FIFO. It supports full- and high-speed SYNC lengths, zero-length packets and FIFO-underrun abort.

---
 rtl/usb_tx_packet_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/usb_tx_packet_sequencer.sv
// USB transmit packet sequencer: emits SYNC, PID, payload and CRC16 as a byte
// stream over a valid/ready handshake, then requests EOP from the serializer.
module usb_tx_packet_sequencer #(
  parameter int unsigned MAX_PAYLOAD = 64,
  parameter int unsigned SIZE_W      = $clog2(MAX_PAYLOAD + 1),
  parameter int unsigned SYNC_BYTES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [3:0]        tx_pid,
  input  logic              tx_has_data,
  input  logic [SIZE_W-1:0] tx_size,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_error,
  input  logic [7:0]        fifo_rdata,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [7:0]        byte_out,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              eop_start,
  input  logic              eop_done
);

  localparam int unsigned       SYNC_W   = $clog2(SYNC_BYTES) + 1;
  localparam logic [SIZE_W-1:0] MaxSize  = SIZE_W'(MAX_PAYLOAD);
  localparam logic [SYNC_W-1:0] SyncLast = SYNC_W'(SYNC_BYTES - 1);

  typedef enum logic [3:0] {
    StIdle,
    StSync,
    StPid,
    StData,
    StCrcLo,
    StCrcHi,
    StEopReq,
    StEopWait,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        pid_q, pid_d;
  logic              has_data_q, has_data_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [SIZE_W-1:0] cnt_q, cnt_d;
  logic [SIZE_W-1:0] cnt_inc;
  logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [15:0]       crc_q, crc_d;
  logic              error_q, error_d;
  logic              xfer;

  // USB CRC16, reflected polynomial, one byte processed LSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  assign xfer    = byte_valid & byte_ready;
  assign cnt_inc = cnt_q + SIZE_W'(1);

  // State, packet descriptor, counters and CRC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pid_q      <= 4'h0;
      has_data_q <= 1'b0;
      size_q     <= '0;
      cnt_q      <= '0;
      sync_cnt_q <= '0;
      crc_q      <= 16'hFFFF;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pid_q      <= pid_d;
      has_data_q <= has_data_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      sync_cnt_q <= sync_cnt_d;
      crc_q      <= crc_d;
      error_q    <= error_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    pid_d      = pid_q;
    has_data_d = has_data_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    sync_cnt_d = sync_cnt_q;
    crc_d      = crc_q;
    error_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tx_start) begin
          pid_d      = tx_pid;
          has_data_d = tx_has_data;
          size_d     = (tx_size > MaxSize) ? MaxSize : tx_size;
          crc_d      = 16'hFFFF;
          cnt_d      = '0;
          sync_cnt_d = '0;
          state_d    = StSync;
        end
      end
      StSync: begin
        if (xfer) begin
          if (sync_cnt_q == SyncLast) state_d = StPid;
          else                        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
        end
      end
      StPid: begin
        if (xfer) begin
          if (!has_data_q)          state_d = StEopReq;
          else if (size_q == '0)    state_d = StCrcLo;
          else                      state_d = StData;
        end
      end
      StData: begin
        if (xfer) begin
          crc_d = crc16_step(crc_q, fifo_rdata);
          cnt_d = cnt_inc;
          if (cnt_inc == size_q) state_d = StCrcLo;
        end else if (byte_ready && fifo_empty) begin
          // Serializer is starving: abandon the packet without a CRC.
          error_d = 1'b1;
          state_d = StEopReq;
        end
      end
      StCrcLo:   if (xfer) state_d = StCrcHi;
      StCrcHi:   if (xfer) state_d = StEopReq;
      StEopReq:  state_d = StEopWait;
      StEopWait: if (eop_done) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Outputs decoded from state, counters and FIFO inputs.
  always_comb begin
    byte_out   = 8'h00;
    byte_valid = 1'b0;
    fifo_rd    = 1'b0;
    eop_start  = 1'b0;
    tx_done    = 1'b0;
    tx_busy    = (state_q != StIdle);
    tx_error   = error_q;
    unique case (state_q)
      StSync: begin
        byte_valid = 1'b1;
        byte_out   = (sync_cnt_q == SyncLast) ? 8'h80 : 8'h00;
      end
      StPid: begin
        byte_valid = 1'b1;
        byte_out   = {~pid_q, pid_q};
      end
      StData: begin
        byte_valid = ~fifo_empty;
        byte_out   = fifo_rdata;
        fifo_rd    = ~fifo_empty & byte_ready;
      end
      StCrcLo: begin
        byte_valid = 1'b1;
        byte_out   = ~crc_q[7:0];
      end
      StCrcHi: begin
        byte_valid = 1'b1;
        byte_out   = ~crc_q[15:8];
      end
      StEopReq: eop_start = 1'b1;
      StDone:   tx_done = 1'b1;
      default: ;
    endcase
  end

endmodule
